// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the FPGA configuration loader.
package fpga_cfg_pkg;

  // Loader FSM encoding; also exported on the loader's fsm_state output.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_RDOUT = 3'd3,
    ST_DONE  = 3'd4
  } cfg_state_t;

  // Operation modes as sampled on cfg_mode with cfg_start.
  localparam logic CFG_WRITE = 1'b0;
  localparam logic CFG_READ  = 1'b1;

  // Chain currently being written or read back; CLB always goes first.
  typedef enum logic {
    CHAIN_CLB  = 1'b0,
    CHAIN_CONN = 1'b1
  } chain_t;

  // Larger of two chain lengths, used to size the bit counters.
  function automatic int max_len(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fpga_cfg_shifter.sv
// WORD_W serialiser/deserialiser. A parallel load clears the bit index;
// every shift step presents word[idx] on serial_out and, when capturing,
// stores serial_in into word[idx] before advancing the index.
module fpga_cfg_shifter #(
  parameter int WORD_W = 8,
  localparam int IDX_W = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  input  logic              capture,
  input  logic              serial_in,
  output logic [WORD_W-1:0] word,
  output logic              serial_out,
  output logic [IDX_W-1:0]  idx
);

  // Word register and bit index: load has priority over shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      idx  <= '0;
    end else if (load) begin
      word <= load_data;
      idx  <= '0;
    end else if (shift) begin
      if (capture) begin
        word[idx] <= serial_in;
      end
      idx <= idx + IDX_W'(1);
    end
  end

  assign serial_out = word[idx];

endmodule

// File: rtl/fpga_cfg_loader.sv
// Configuration loader for the CLB and connection scan chains. Writes a
// word-wide bitstream onto CLB then CONN, one bit per clock, or reads both
// chains back non-destructively by recirculating each chain into itself.
//
// Handshakes: a word moves on cfg_* when cfg_valid & cfg_ready are both high
// on a rising edge, and on rd_* when rd_valid & rd_ready are both high. The
// producer holds valid and data stable until the transfer; ready never waits
// on valid. cfg_ready is only high in FETCH during a write; rd_valid is only
// high in RDOUT and holds rd_data unchanged until taken.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int WORD_W   = 8,
  parameter int CLB_LEN  = 2048,
  parameter int CONN_LEN = 4096
) (
  input  logic              scan_clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_mode,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              clb_scan_in,
  output logic              clb_scan_en,
  input  logic              clb_scan_out,
  output logic              conn_scan_in,
  output logic              conn_scan_en,
  input  logic              conn_scan_out,
  output logic              busy,
  output logic              done,
  output cfg_state_t        fsm_state
);

  localparam int MAX_LEN = max_len(CLB_LEN, CONN_LEN);
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int IDX_W   = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CLB_LEN_C  = CNT_W'(CLB_LEN);
  localparam logic [CNT_W-1:0] CONN_LEN_C = CNT_W'(CONN_LEN);

  cfg_state_t        state;
  logic              mode;
  chain_t            chain;
  logic [CNT_W-1:0]  remaining;
  logic [IDX_W-1:0]  last_idx;

  logic [CNT_W-1:0]  n_bits;
  logic [IDX_W-1:0]  n_last;
  logic              sh_load;
  logic              sh_shift;
  logic              sh_in;
  logic              sh_bit;
  logic [WORD_W-1:0] sh_word;
  logic [WORD_W-1:0] load_word;
  logic [IDX_W-1:0]  sh_idx;
  logic              word_end;

  cfg_state_t        adv_state;
  chain_t            adv_chain;
  logic [CNT_W-1:0]  adv_remaining;
  logic              adv_ready;
  logic              adv_done;

  // Bits in the next word: a full word, or whatever is left of the chain.
  always_comb begin
    if (32'(remaining) >= 32'(WORD_W)) begin
      n_bits = CNT_W'(WORD_W);
    end else begin
      n_bits = remaining;
    end
    n_last = IDX_W'(n_bits - CNT_W'(1));
  end

  // Where to go once a word has been fully handled (shifted or read out).
  always_comb begin
    adv_state     = ST_FETCH;
    adv_chain     = chain;
    adv_remaining = remaining;
    adv_ready     = (mode == CFG_WRITE);
    adv_done      = 1'b0;
    if (remaining == '0) begin
      if (chain == CHAIN_CLB) begin
        adv_chain     = CHAIN_CONN;
        adv_remaining = CONN_LEN_C;
      end else begin
        adv_state = ST_DONE;
        adv_ready = 1'b0;
        adv_done  = 1'b1;
      end
    end
  end

  // Readback words start from zero so a short final word is zero-padded.
  assign load_word = (mode == CFG_WRITE) ? cfg_data : '0;
  assign sh_load   = (state == ST_FETCH) &&
                     ((mode == CFG_READ) || (cfg_valid && cfg_ready));
  assign sh_shift  = (state == ST_SHIFT);
  assign word_end  = sh_shift && (sh_idx == last_idx);
  assign sh_in     = (chain == CHAIN_CLB) ? clb_scan_out : conn_scan_out;

  fpga_cfg_shifter #(
    .WORD_W (WORD_W)
  ) u_shifter (
    .clk        (scan_clk),
    .rst        (rst),
    .load       (sh_load),
    .load_data  (load_word),
    .shift      (sh_shift),
    .capture    (mode == CFG_READ),
    .serial_in  (sh_in),
    .word       (sh_word),
    .serial_out (sh_bit),
    .idx        (sh_idx)
  );

  // Loader FSM with registered handshake, status and chain-enable outputs.
  always_ff @(posedge scan_clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      mode         <= CFG_WRITE;
      chain        <= CHAIN_CLB;
      remaining    <= '0;
      last_idx     <= '0;
      cfg_ready    <= 1'b0;
      rd_valid     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      clb_scan_en  <= 1'b0;
      conn_scan_en <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            state     <= ST_FETCH;
            mode      <= cfg_mode;
            chain     <= CHAIN_CLB;
            remaining <= CLB_LEN_C;
            busy      <= 1'b1;
            cfg_ready <= (cfg_mode == CFG_WRITE);
          end
        end
        ST_FETCH: begin
          if (sh_load) begin
            state        <= ST_SHIFT;
            cfg_ready    <= 1'b0;
            remaining    <= remaining - n_bits;
            last_idx     <= n_last;
            clb_scan_en  <= (chain == CHAIN_CLB);
            conn_scan_en <= (chain == CHAIN_CONN);
          end
        end
        ST_SHIFT: begin
          if (word_end) begin
            clb_scan_en  <= 1'b0;
            conn_scan_en <= 1'b0;
            if (mode == CFG_READ) begin
              state    <= ST_RDOUT;
              rd_valid <= 1'b1;
            end else begin
              state     <= adv_state;
              chain     <= adv_chain;
              remaining <= adv_remaining;
              cfg_ready <= adv_ready;
              done      <= adv_done;
            end
          end
        end
        ST_RDOUT: begin
          if (rd_ready) begin
            rd_valid  <= 1'b0;
            state     <= adv_state;
            chain     <= adv_chain;
            remaining <= adv_remaining;
            cfg_ready <= adv_ready;
            done      <= adv_done;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Write drives the shifter bit; readback loops the tail back to the head.
  assign clb_scan_in  = clb_scan_en &
                        ((mode == CFG_READ) ? clb_scan_out : sh_bit);
  assign conn_scan_in = conn_scan_en &
                        ((mode == CFG_READ) ? conn_scan_out : sh_bit);

  assign rd_data   = sh_word;
  assign fsm_state = state;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: two instances (CLB_LEN 10 and 16, CONN_LEN 6)
// attached to behavioural scan-chain models, checked against a bit-level
// reference of what each chain must receive and return.
module tb_fpga_cfg_loader;
  import fpga_cfg_pkg::*;

  // ---------------- clock / reset ----------------
  logic scan_clk = 1'b0;
  logic rst = 1'b1;
  always #5 scan_clk = ~scan_clk;

  int cycle = 0;
  always @(posedge scan_clk) cycle <= cycle + 1;

  // ---------------- shared stimulus ----------------
  logic       sel = 1'b0;
  logic       cfg_start = 1'b0;
  logic       cfg_mode = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       cfg_valid = 1'b0;
  logic       rd_ready = 1'b0;
  logic       a_start, b_start;
  assign a_start = cfg_start & ~sel;
  assign b_start = cfg_start & sel;

  // ---------------- DUT outputs ----------------
  logic       a_ready, a_rd_valid, a_clb_in, a_clb_en, a_conn_in, a_conn_en, a_busy, a_done;
  logic       b_ready, b_rd_valid, b_clb_in, b_clb_en, b_conn_in, b_conn_en, b_busy, b_done;
  logic [7:0] a_rd_data, b_rd_data;
  cfg_state_t a_state, b_state;

  // ---------------- scan chain models ----------------
  logic [9:0]  a_clb_chain = '0;
  logic [5:0]  a_conn_chain = '0;
  logic [15:0] b_clb_chain = '0;
  logic [5:0]  b_conn_chain = '0;
  logic a_clb_out, a_conn_out, b_clb_out, b_conn_out;
  assign a_clb_out  = a_clb_chain[9];
  assign a_conn_out = a_conn_chain[5];
  assign b_clb_out  = b_clb_chain[15];
  assign b_conn_out = b_conn_chain[5];

  always @(posedge scan_clk) begin
    if (a_clb_en)  a_clb_chain  <= {a_clb_chain[8:0], a_clb_in};
    if (a_conn_en) a_conn_chain <= {a_conn_chain[4:0], a_conn_in};
    if (b_clb_en)  b_clb_chain  <= {b_clb_chain[14:0], b_clb_in};
    if (b_conn_en) b_conn_chain <= {b_conn_chain[4:0], b_conn_in};
  end

  fpga_cfg_loader #(.WORD_W(8), .CLB_LEN(10), .CONN_LEN(6)) dut (
    .scan_clk(scan_clk), .rst(rst), .cfg_start(a_start), .cfg_mode(cfg_mode),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(a_ready),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_ready(rd_ready),
    .clb_scan_in(a_clb_in), .clb_scan_en(a_clb_en), .clb_scan_out(a_clb_out),
    .conn_scan_in(a_conn_in), .conn_scan_en(a_conn_en), .conn_scan_out(a_conn_out),
    .busy(a_busy), .done(a_done), .fsm_state(a_state)
  );

  fpga_cfg_loader #(.WORD_W(8), .CLB_LEN(16), .CONN_LEN(6)) dut16 (
    .scan_clk(scan_clk), .rst(rst), .cfg_start(b_start), .cfg_mode(cfg_mode),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(b_ready),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_ready(rd_ready),
    .clb_scan_in(b_clb_in), .clb_scan_en(b_clb_en), .clb_scan_out(b_clb_out),
    .conn_scan_in(b_conn_in), .conn_scan_en(b_conn_en), .conn_scan_out(b_conn_out),
    .busy(b_busy), .done(b_done), .fsm_state(b_state)
  );

  // Selected instance view
  logic       c_ready, c_rd_valid, c_clb_in, c_clb_en, c_conn_in, c_conn_en, c_busy, c_done;
  logic [7:0] c_rd_data;
  cfg_state_t c_state;
  assign c_ready    = sel ? b_ready    : a_ready;
  assign c_rd_valid = sel ? b_rd_valid : a_rd_valid;
  assign c_rd_data  = sel ? b_rd_data  : a_rd_data;
  assign c_clb_in   = sel ? b_clb_in   : a_clb_in;
  assign c_clb_en   = sel ? b_clb_en   : a_clb_en;
  assign c_conn_in  = sel ? b_conn_in  : a_conn_in;
  assign c_conn_en  = sel ? b_conn_en  : a_conn_en;
  assign c_busy     = sel ? b_busy     : a_busy;
  assign c_done     = sel ? b_done     : a_done;
  assign c_state    = sel ? b_state    : a_state;

  // ---------------- monitor ----------------
  logic clb_log[$];
  logic conn_log[$];
  int   done_cnt = 0, overlap = 0, stray = 0;

  always @(negedge scan_clk) begin
    if (c_clb_en)  clb_log.push_back(c_clb_in);
    if (c_conn_en) conn_log.push_back(c_conn_in);
    if (c_clb_en && c_conn_en) overlap++;
    if ((!c_clb_en && c_clb_in) || (!c_conn_en && c_conn_in)) stray++;
    if (c_done) done_cnt++;
  end

  // ---------------- scoreboard ----------------
  int total = 0, bad = 0;
  logic       ref_clb[$];
  logic       ref_conn[$];
  int         ref_n[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_bits(input logic q[$]);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < q.size() && i < 64; i++) v[i] = q[i];
    return v;
  endfunction

  // Reference: each chain receives its words bit 0 first, truncated to its length.
  task automatic build_ref(input logic [7:0] w[$], input int clb_len, input int conn_len);
    int k, len, cnt;
    k = 0;
    ref_clb.delete(); ref_conn.delete(); ref_n.delete();
    for (int c = 0; c < 2; c++) begin
      len = (c == 0) ? clb_len : conn_len;
      for (int i = 0; i < (len + 7) / 8; i++) begin
        cnt = 0;
        for (int j = 0; j < 8; j++) begin
          if (i * 8 + j < len) begin
            if (c == 0) ref_clb.push_back(w[k][j]);
            else        ref_conn.push_back(w[k][j]);
            cnt++;
          end
        end
        ref_n.push_back(cnt);
        k++;
      end
    end
  endtask

  task automatic fill_exp(input logic b[$]);
    logic [7:0] wd;
    for (int i = 0; i < b.size(); i += 8) begin
      wd = '0;
      for (int j = 0; j < 8; j++) if (i + j < b.size()) wd[j] = b[i + j];
      exp_q.push_back(wd);
    end
  endtask

  task automatic reset_mon();
    clb_log.delete(); conn_log.delete();
    done_cnt = 0; overlap = 0; stray = 0;
  endtask

  task automatic check_logs(input string tag);
    chk({tag, "_clb_len"},  clb_log.size(),  ref_clb.size());
    chk({tag, "_clb_bits"}, pack_bits(clb_log), pack_bits(ref_clb));
    chk({tag, "_conn_len"}, conn_log.size(), ref_conn.size());
    chk({tag, "_conn_bits"}, pack_bits(conn_log), pack_bits(ref_conn));
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_en_excl"}, overlap, 0);
    chk({tag, "_idle_scan_in"}, stray, 0);
  endtask

  // ---------------- driver tasks (all start and end on a negedge) ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    while (!c_ready && n < 100) begin @(negedge scan_clk); n++; end
    chk("ready_seen", c_ready, 1'b1);
  endtask

  task automatic start_op(input logic mode);
    cfg_start = 1'b1; cfg_mode = mode;
    @(posedge scan_clk); @(negedge scan_clk);
    cfg_start = 1'b0;
    chk("start_busy", c_busy, 1'b1);
    chk("start_ready", c_ready, mode == CFG_WRITE);
  endtask

  task automatic do_write(input logic [7:0] w[$], input int gap, input bit poke);
    int acc, prev, n;
    build_ref(w, sel ? 16 : 10, 6);
    reset_mon();
    start_op(CFG_WRITE);
    acc = 0;
    for (int i = 0; i < w.size(); i++) begin
      cfg_data = w[i]; cfg_valid = 1'b1;
      wait_ready();
      prev = acc; acc = cycle;
      if (i > 0 && gap == 0) chk("word_cost", acc - prev, ref_n[i-1] + 1);
      @(posedge scan_clk); @(negedge scan_clk);
      chk("accept_resp", {c_ready, c_clb_en | c_conn_en}, 2'b01);
      if (gap > 0 || i == w.size() - 1) cfg_valid = 1'b0;
      if (poke && i == 0) begin
        cfg_start = 1'b1; @(negedge scan_clk); cfg_start = 1'b0;
        chk("start_ignored", {c_busy, c_ready, c_state}, {1'b1, 1'b0, ST_SHIFT});
      end
      if (gap > 0 && i < w.size() - 1) begin
        wait_ready();
        for (int g = 0; g < gap; g++) begin
          if (g > 0) @(negedge scan_clk);
          chk("gap_en_low", {c_clb_en, c_conn_en, c_ready}, 3'b001);
        end
      end
    end
    n = 0;
    while (!c_done && n < 100) begin @(negedge scan_clk); n++; end
    chk("wr_done_time", cycle - acc, ref_n[w.size() - 1] + 1);
    @(negedge scan_clk);
    chk("wr_idle", {c_busy, c_done, c_state}, {2'b00, ST_IDLE});
    check_logs("wr");
  endtask

  task automatic do_read(input int stall_idx, input int stall_len);
    int nw, n;
    logic [7:0] exp;
    exp_q.delete();
    fill_exp(ref_clb);
    fill_exp(ref_conn);
    nw = exp_q.size();
    reset_mon();
    start_op(CFG_READ);
    for (int i = 0; i < nw; i++) begin
      rd_ready = (i != stall_idx);
      n = 0;
      while (!c_rd_valid && n < 100) begin @(negedge scan_clk); n++; end
      chk("rd_valid_seen", c_rd_valid, 1'b1);
      exp = exp_q.pop_front();
      chk("rd_word", c_rd_data, exp);
      chk("rd_en_low", {c_clb_en, c_conn_en}, 2'b00);
      if (i == stall_idx) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge scan_clk);
          chk("stall_hold", {c_rd_valid, c_rd_data, c_clb_en, c_conn_en}, {1'b1, exp, 2'b00});
        end
        rd_ready = 1'b1;
      end
      @(negedge scan_clk);
      chk("rd_valid_drop", c_rd_valid, 1'b0);
      if (i == nw - 1) chk("rd_done", c_done, 1'b1);
    end
    @(negedge scan_clk);
    chk("rd_idle", {c_busy, c_state}, {1'b0, ST_IDLE});
    check_logs("rd");
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] w[$];
    int gap;

    repeat (3) @(posedge scan_clk);
    @(negedge scan_clk);
    chk("reset_outs", {a_ready, a_rd_valid, a_busy, a_done, a_clb_en, a_conn_en, a_clb_in, a_conn_in}, 8'h00);
    chk("reset_rd_data", a_rd_data, 8'h00);
    chk("reset_state", a_state, ST_IDLE);
    rst = 1'b0;
    @(negedge scan_clk);

    // Known bitstream, valid held high, then with 5-cycle gaps
    w = '{8'hA5, 8'h03, 8'h2C};
    do_write(w, 0, 1'b0);
    do_write(w, 5, 1'b0);

    // Readback twice (non-destructive), then with a 7-cycle stall on word 1
    do_read(-1, 0);
    do_read(-1, 0);
    do_read(0, 7);

    // cfg_start pulsed mid-write must be ignored
    w = '{8'h5A, 8'hC1, 8'h17};
    do_write(w, 0, 1'b1);
    do_read(-1, 0);

    // Reset during the 4th CLB shift, then a fresh write
    reset_mon();
    start_op(CFG_WRITE);
    cfg_data = 8'h96; cfg_valid = 1'b1;
    wait_ready();
    @(posedge scan_clk); @(negedge scan_clk);
    cfg_valid = 1'b0;
    repeat (3) @(negedge scan_clk);
    chk("pre_rst_en", {c_clb_en, clb_log.size() >= 3}, 2'b11);
    rst = 1'b1;
    @(negedge scan_clk);
    chk("rst_outs", {c_ready, c_rd_valid, c_busy, c_done, c_clb_en, c_conn_en, c_clb_in, c_conn_in}, 8'h00);
    chk("rst_state", c_state, ST_IDLE);
    chk("rst_rd_data", c_rd_data, 8'h00);
    rst = 1'b0;
    @(negedge scan_clk);
    w = '{8'h3C, 8'h02, 8'h15};
    do_write(w, 0, 1'b0);
    do_read(-1, 0);

    // Random words, gaps and stalls
    for (int r = 0; r < 4; r++) begin
      w.delete();
      repeat (3) w.push_back(8'($urandom_range(0, 255)));
      gap = $urandom_range(0, 3);
      do_write(w, gap, 1'b0);
      do_read($urandom_range(0, 2), $urandom_range(1, 4));
    end

    // 16-bit CLB chain: exact word multiple, then CONN
    sel = 1'b1;
    @(negedge scan_clk);
    w = '{8'hFF, 8'h00, 8'h2C};
    do_write(w, 0, 1'b0);
    do_read(-1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so a stuck handshake cannot hang the run
  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fpga_cfg_loader.md
# fpga_cfg_loader

Parametrised configuration loader for the FPGA core's two scan chains (CLB and connection). It accepts a word-wide bitstream over a valid/ready handshake and serialises it onto the CLB chain, then the connection chain, one bit per clock. It also supports non-destructive readback: each chain is recirculated through itself while its bits are packed into output words. It sits between the chip configuration port and the core's `clb_scan_*` and `conn_scan_*` pins, and replaces direct pin-driven scan.

## Interface
Parameters:
- `WORD_W`, 8, bitstream word width (≥2).
- `CLB_LEN`, 2048, CLB chain length in bits (≥1).
- `CONN_LEN`, 4096, connection chain length in bits, edge plus tile (≥1).

Ports:
- `scan_clk`  in  1  sole clock; the same clock drives the fabric scan chains.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_start`  in  1  starts an operation; sampled only in IDLE.
- `cfg_mode`  in  1  sampled with `cfg_start`: 0 = write, 1 = readback.
- `cfg_data`  in  WORD_W  write word; bit 0 is shifted first.
- `cfg_valid`  in  1  write word valid.
- `cfg_ready`  out  1  loader can accept a write word.
- `rd_data`  out  WORD_W  readback word; bit 0 is the first bit out.
- `rd_valid`  out  1  readback word valid.
- `rd_ready`  in  1  consumer accepts the readback word.
- `clb_scan_in`, `clb_scan_en`  out  1  CLB chain data and enable.
- `clb_scan_out`  in  1  CLB chain tail.
- `conn_scan_in`, `conn_scan_en`  out  1  connection chain data and enable.
- `conn_scan_out`  in  1  connection chain tail.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when an operation completes.

## Operation
- States:
  - IDLE → FETCH on `cfg_start`. Chain is set to CLB; the mode is latched.
  - FETCH: in write mode, waits for a word. In readback mode, goes straight to SHIFT.
  - SHIFT: shifts n = min(WORD_W, bits remaining in the current chain) bits, one per cycle.
  - RDOUT: readback only. Holds the packed word until it is accepted.
  - DONE: one cycle, then IDLE.
- After SHIFT (write) or RDOUT (readback):
  - If the current chain still has bits, go to FETCH.
  - Else if the current chain is CLB, switch to CONN and go to FETCH.
  - Else go to DONE.
- Word count per chain is ceil(LEN/WORD_W). In write mode, the unused upper bits of a chain's last word are discarded. In readback mode, they are zero-padded.
- Chains are strictly sequential: CLB first, then CONN. Only the active chain's `*_scan_en` is high, and only during SHIFT.
- Write mode: `*_scan_in` carries the registered word bit k on SHIFT cycle k.
- Readback mode: the active `*_scan_in` equals its `*_scan_out` combinationally, so chain contents are preserved. `*_scan_out` is captured into bit k at the end of SHIFT cycle k.
- Outputs when idle: inactive chain `*_scan_in` = 0, and all enables = 0.
- `cfg_start` in any state other than IDLE is ignored. `cfg_valid` outside FETCH (write) is ignored; the word is not consumed.
- Bit counters are sized `$clog2(max(CLB_LEN,CONN_LEN)+1)`. No wrap is permitted; the remaining-bit count is checked before each word.

## Timing
- Reset values: `cfg_ready`, `rd_valid`, `busy`, `done`, both enables and both `scan_in` outputs = 0; `rd_data` = 0.
- `rst` mid-operation: all of the above hold reset values from the next cycle. Partially shifted chains are left as-is; software reloads them.
- `cfg_start` at cycle t: `busy` = 1 from t+1.
  - Write mode: `cfg_ready` = 1 from t+1.
- Write word accepted at cycle t (`cfg_valid & cfg_ready`):
  - `cfg_ready` = 0 from t+1.
  - SHIFT occupies cycles t+1 … t+n with the enable high.
  - FETCH is re-entered at t+n+1.
  - Back-to-back cost is n+1 cycles per word.
- Readback word: `rd_valid` rises the cycle after the last capture and holds with `rd_data` stable until `rd_valid & rd_ready`. Shifting stays stalled, enables low, meanwhile.
- `done` is asserted the cycle after the final SHIFT (write) or final accepted RDOUT (readback); `busy` falls the following cycle.

## Structure
- Package `fpga_cfg_pkg`: state encoding (IDLE, FETCH, SHIFT, RDOUT, DONE), mode constants (`CFG_WRITE`=0, `CFG_READ`=1), chain-select constants.
- Sub-module `fpga_cfg_shifter`: a WORD_W serialiser/deserialiser with parallel load, serial in/out and bit index. The FSM, chain select and length counters stay in `fpga_cfg_loader`.
- `fpga_core` instantiates the loader, drives its own scan pins from it, and ties `fpga_edge.conn_scan_en` to `conn_scan_en`.

## Test plan
All scenarios use `WORD_W`=8, `CLB_LEN`=10, `CONN_LEN`=6, and a behavioural shift-register model of each chain.
- Write 0xA5, 0x03, 0x2C with `cfg_valid` held high → `clb_scan_in` = 1,0,1,0,0,1,0,1,1,1 with `clb_scan_en` high exactly 10 cycles; `conn_scan_in` = 0,0,1,1,0,1 over 6 cycles; exactly one `done` pulse.
- Same words, but `cfg_valid` dropped for 5 cycles between every word → enables low during the gaps; bit sequences identical.
- Readback after that write, `rd_ready`=1 → `rd_data` = 0xA5, 0x03, 0x2C. An immediate second readback returns the same three words (non-destructive).
- Readback with `rd_ready` held low 7 cycles on word 1 → `rd_valid` and `rd_data` = 0xA5 stable, `clb_scan_en` = 0 throughout the stall.
- Pulse `cfg_start` mid-write → ignored. Assert `rst` during the 4th CLB shift → the next cycle all outputs are 0 and the state is IDLE; a fresh write then completes correctly.
- `CLB_LEN`=16: write 0xFF, 0x00 → 16 CLB shift cycles, no partial word, then the CONN section proceeds normally.
